// File: rtl/fnd_scan_driver_if.sv
// Time-digit inputs and multiplexed 7-segment display outputs of the FND scan driver.
interface fnd_scan_driver_if;
  logic [3:0] cnt_sec1;
  logic [3:0] cnt_sec10;
  logic [3:0] cnt_min1;
  logic [3:0] cnt_min10;
  logic [3:0] cnt_hour1;
  logic [3:0] cnt_hour10;
  logic       blank_lz;
  logic [5:0] blink_mask;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig_sel;
  logic       frame_done;

  modport master (
    output cnt_sec1, cnt_sec10, cnt_min1, cnt_min10, cnt_hour1, cnt_hour10,
    output blank_lz, blink_mask,
    input  seg, dp, dig_sel, frame_done
  );

  modport slave (
    input  cnt_sec1, cnt_sec10, cnt_min1, cnt_min10, cnt_hour1, cnt_hour10,
    input  blank_lz, blink_mask,
    output seg, dp, dig_sel, frame_done
  );
endinterface

// File: rtl/fnd_scan_driver.sv
// 6-digit multiplexed 7-segment scan driver: digit resync, per-frame snapshot,
// anti-ghost blanking, BCD decode, leading-zero blanking, digit blink and colon blink.
module fnd_scan_driver #(
  parameter int unsigned SCAN_DIV       = 25000,
  parameter int unsigned BLANK_CYC      = 2,
  parameter int unsigned BLINK_DIV      = 12500000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  fnd_scan_driver_if.slave bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned KW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned BW = $clog2(BLANK_CYC + 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [5:0] DIG_OFF = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic [PW-1:0] r_presc;
  logic [KW-1:0] r_bk;
  logic          r_phase;
  logic [23:0]   w_din, r_s1, r_s2, r_stable, r_snap, w_snap_nxt;
  logic [6:0]    r_seg, w_seg_nxt, w_seg_hi;
  logic          r_dp, w_dp_nxt, w_dp_hi;
  logic [5:0]    r_dig, w_dig_nxt, w_onehot;
  logic          r_fd, w_fd_nxt;
  logic          w_tick, w_btog, w_phase_nxt, w_blank;
  logic [3:0]    w_digit;

  assign w_din = {bus.cnt_hour10, bus.cnt_hour1, bus.cnt_min10,
                  bus.cnt_min1, bus.cnt_sec10, bus.cnt_sec1};

  // Two-flop resync; stable only takes values seen identically on two samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
    end else begin
      r_s1 <= w_din;
      r_s2 <= r_s1;
      if (r_s1 == r_s2) r_stable <= r_s2;
    end
  end

  assign w_tick      = (r_presc == PW'(SCAN_DIV - 1));
  assign w_btog      = (r_bk == KW'(BLINK_DIV - 1));
  assign w_phase_nxt = r_phase ^ w_btog;

  // Digit-slot prescaler and free-running blink timebase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
      r_bk    <= '0;
      r_phase <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_bk    <= w_btog ? '0 : r_bk + KW'(1);
      r_phase <= w_phase_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_BLANK;
      r_idx   <= 3'd0;
      r_bcnt  <= '0;
      r_snap  <= '0;
      r_seg   <= SEG_OFF;
      r_dp    <= DP_OFF;
      r_dig   <= DIG_OFF;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_snap  <= w_snap_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
      r_dig   <= w_dig_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  // Slot sequencing; segments are decoded once per slot from the (possibly new) snapshot.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_bcnt_nxt  = r_bcnt;
    w_snap_nxt  = r_snap;
    w_seg_nxt   = r_seg;
    w_dp_nxt    = r_dp;
    w_fd_nxt    = 1'b0;
    w_digit     = 4'd0;
    w_blank     = 1'b0;
    w_seg_hi    = 7'h00;
    w_dp_hi     = 1'b0;
    w_onehot    = 6'd0;
    w_dig_nxt   = DIG_OFF;

    if (w_tick) begin
      w_state_nxt = ST_BLANK;
      w_bcnt_nxt  = '0;
      w_idx_nxt   = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      if (r_idx == 3'd5) begin
        w_fd_nxt   = 1'b1;
        w_snap_nxt = r_stable;
      end
      w_digit = w_snap_nxt[{w_idx_nxt, 2'b00} +: 4];
      w_blank = ((w_idx_nxt == 3'd5) && bus.blank_lz && (w_digit == 4'd0)) ||
                (bus.blink_mask[w_idx_nxt] && w_phase_nxt);
      case (w_digit)
        4'd0:    w_seg_hi = 7'h3F;
        4'd1:    w_seg_hi = 7'h06;
        4'd2:    w_seg_hi = 7'h5B;
        4'd3:    w_seg_hi = 7'h4F;
        4'd4:    w_seg_hi = 7'h66;
        4'd5:    w_seg_hi = 7'h6D;
        4'd6:    w_seg_hi = 7'h7D;
        4'd7:    w_seg_hi = 7'h07;
        4'd8:    w_seg_hi = 7'h7F;
        4'd9:    w_seg_hi = 7'h6F;
        default: w_seg_hi = 7'h40;
      endcase
      if (w_blank) w_seg_hi = 7'h00;
      w_dp_hi   = !w_blank && ((w_idx_nxt == 3'd2) || (w_idx_nxt == 3'd4)) && !w_phase_nxt;
      w_seg_nxt = SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
      w_dp_nxt  = SEG_ACTIVE_LOW ? ~w_dp_hi : w_dp_hi;
    end else if (r_state == ST_BLANK) begin
      if (r_bcnt == BW'(BLANK_CYC - 1)) w_state_nxt = ST_DRIVE;
      else                              w_bcnt_nxt  = r_bcnt + BW'(1);
    end

    w_onehot = 6'b000001 << w_idx_nxt;
    if (w_state_nxt == ST_DRIVE) w_dig_nxt = DIG_ACTIVE_LOW ? ~w_onehot : w_onehot;
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.dig_sel    = r_dig;
  assign bus.frame_done = r_fd;

endmodule
